branch_hazard_unit: RTL and testbench

- Drives the `branch_status[1:0]` and `want_stall` inputs of the pipeline controller.
- Answers that controller's `jump_start` with a timed redirect/release sequence.
- Detects load-use hazards between the decode (ID) and execute (EX) stages.
- Sits beside the pipeline controller in the decode stage and is fed by EX-stage register tags.

---
 rtl/branch_hazard_unit_pkg.sv | 18 +
 rtl/branch_hazard_unit_load_use_detect.sv | 25 ++
 rtl/branch_hazard_unit.sv | 132 +++++++++++++
 tb/tb_branch_hazard_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_hazard_unit_pkg.sv
// Shared control constants for the decode-stage branch/hazard logic:
// branch_status codes driven to the pipeline controller and the jump FSM state type.
package branch_hazard_unit_pkg;

    localparam logic [1:0] BRANCH_STATUS_IDLE     = 2'b00;
    localparam logic [1:0] BRANCH_STATUS_REDIRECT = 2'b01;
    localparam logic [1:0] BRANCH_STATUS_RELEASE  = 2'b10;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT     = 2'b01,
        ST_REDIRECT = 2'b10,
        ST_RELEASE  = 2'b11
    } branch_state_t;

endpackage

// File: rtl/branch_hazard_unit_load_use_detect.sv
// Pure-combinational load-use compare between the ID source operands and the EX load
// destination; the result is the raw stall before any FSM-state gating.
module load_use_detect
    import branch_hazard_unit_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_uses_rs1,
    input  logic                 i_id_uses_rs2,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_ex_is_load,
    output logic                 o_raw_stall
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_live;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign w_rd_live   = i_ex_is_load && (i_ex_rd != '0);
    assign w_rs1_hit   = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit   = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_raw_stall = w_rd_live && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/branch_hazard_unit.sv
// Decode-stage branch sequencer (IDLE/WAIT/REDIRECT/RELEASE) plus load-use stall request.
// Optional statistics counters are built when BRANCH_HAZARD_STATS_EN is defined.
module branch_hazard_unit
    import branch_hazard_unit_pkg::*;
#(
    parameter int RESOLVE_LATENCY = 2,
    parameter int CNT_W           = 4
`ifdef BRANCH_HAZARD_STATS_EN
    ,
    parameter int STAT_W          = 32
`endif
)(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 jump_start,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_load,
    output logic [1:0]           branch_status,
    output logic                 want_stall
`ifdef BRANCH_HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_jumps,
    output logic [STAT_W-1:0]    stat_stalls
`endif
);

    // WAIT is entered one cycle after acceptance and REDIRECT one cycle after the
    // counter reaches zero, hence the load value of LATENCY-2.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (RESOLVE_LATENCY > 1) ? CNT_W'(RESOLVE_LATENCY - 2) : '0;

    branch_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_status;
    logic             w_raw_stall;
    logic             w_want_stall;
    logic             w_accept;

    load_use_detect u_load_use_detect (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_ex_rd       (ex_rd),
        .i_ex_is_load  (ex_is_load),
        .o_raw_stall   (w_raw_stall)
    );

    // Operands are already captured once a jump is underway, so only IDLE can stall.
    assign w_want_stall = w_raw_stall && (r_state == ST_IDLE);
    assign w_accept     = jump_start && !w_want_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_status <= BRANCH_STATUS_IDLE;
        end else if (flush) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_status <= BRANCH_STATUS_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (RESOLVE_LATENCY == 1) begin
                            r_state  <= ST_REDIRECT;
                            r_status <= BRANCH_STATUS_REDIRECT;
                        end else begin
                            r_state  <= ST_WAIT;
                            r_cnt    <= CNT_LOAD;
                            r_status <= BRANCH_STATUS_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state  <= ST_REDIRECT;
                        r_status <= BRANCH_STATUS_REDIRECT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_REDIRECT: begin
                    r_state  <= ST_RELEASE;
                    r_status <= BRANCH_STATUS_RELEASE;
                end
                ST_RELEASE: begin
                    r_state  <= ST_IDLE;
                    r_status <= BRANCH_STATUS_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    r_status <= BRANCH_STATUS_IDLE;
                end
            endcase
        end
    end

    assign branch_status = r_status;
    assign want_stall    = w_want_stall;

`ifdef BRANCH_HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stat_jumps;
    logic [STAT_W-1:0] r_stat_stalls;

    // A flush in RELEASE aborts the hand-off, so that jump is not counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_jumps  <= '0;
            r_stat_stalls <= '0;
        end else begin
            if ((r_state == ST_RELEASE) && !flush) begin
                r_stat_jumps <= r_stat_jumps + STAT_W'(1);
            end
            if (w_want_stall && !flush) begin
                r_stat_stalls <= r_stat_stalls + STAT_W'(1);
            end
        end
    end

    assign stat_jumps  = r_stat_jumps;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Bench for branch_hazard_unit: three instances (RESOLVE_LATENCY 1, 2, 3) share stimulus;
// expected status/stall values are queued per cycle and popped against the outputs.
module tb_branch_hazard_unit;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       jump_start;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_is_load;

    logic [1:0] st1, st2, st3;
    logic       ws1, ws2, ws3;

    int n_pass  = 0;
    int n_total = 0;

    logic [1:0] q1[$];
    logic [1:0] q2[$];
    logic [1:0] q3[$];
    logic       qw[$];

`ifdef BRANCH_HAZARD_STATS_EN
    logic [3:0] sj1, sj2, sj3, ss1, ss2, ss3;
    logic [3:0] ej1 = '0, ej2 = '0, ej3 = '0, es = '0;
`endif

    always #5 clock = ~clock;

    branch_hazard_unit #(.RESOLVE_LATENCY(1), .CNT_W(4)
`ifdef BRANCH_HAZARD_STATS_EN
        , .STAT_W(4)
`endif
    ) u_dut1 (
        .clock(clock), .reset_n(reset_n), .flush(flush), .jump_start(jump_start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .branch_status(st1), .want_stall(ws1)
`ifdef BRANCH_HAZARD_STATS_EN
        , .stat_jumps(sj1), .stat_stalls(ss1)
`endif
    );

    branch_hazard_unit #(.RESOLVE_LATENCY(2), .CNT_W(4)
`ifdef BRANCH_HAZARD_STATS_EN
        , .STAT_W(4)
`endif
    ) u_dut2 (
        .clock(clock), .reset_n(reset_n), .flush(flush), .jump_start(jump_start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .branch_status(st2), .want_stall(ws2)
`ifdef BRANCH_HAZARD_STATS_EN
        , .stat_jumps(sj2), .stat_stalls(ss2)
`endif
    );

    branch_hazard_unit #(.RESOLVE_LATENCY(3), .CNT_W(4)
`ifdef BRANCH_HAZARD_STATS_EN
        , .STAT_W(4)
`endif
    ) u_dut3 (
        .clock(clock), .reset_n(reset_n), .flush(flush), .jump_start(jump_start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .branch_status(st3), .want_stall(ws3)
`ifdef BRANCH_HAZARD_STATS_EN
        , .stat_jumps(sj3), .stat_stalls(ss3)
`endif
    );

    task automatic set_hazard(input logic ld, input logic [4:0] rd,
                              input logic u1, input logic [4:0] r1,
                              input logic u2, input logic [4:0] r2);
        ex_is_load  = ld;
        ex_rd       = rd;
        id_uses_rs1 = u1;
        id_rs1      = r1;
        id_uses_rs2 = u2;
        id_rs2      = r2;
    endtask

    task automatic test_reset();
        flush = 1'b0;
        jump_start = 1'b0;
        set_hazard(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_total++; if (st1 !== 2'b00) $display("FAIL reset_st1 got=%b want=00", st1); else n_pass++;
        n_total++; if (st2 !== 2'b00) $display("FAIL reset_st2 got=%b want=00", st2); else n_pass++;
        n_total++; if (st3 !== 2'b00) $display("FAIL reset_st3 got=%b want=00", st3); else n_pass++;
        n_total++; if ({ws1, ws2, ws3} !== 3'b000) $display("FAIL reset_stall got=%b want=000", {ws1, ws2, ws3}); else n_pass++;
`ifdef BRANCH_HAZARD_STATS_EN
        n_total++; if ({sj1, sj2, sj3, ss1, ss2, ss3} !== 24'd0) $display("FAIL reset_stats got=%h want=0", {sj1, sj2, sj3, ss1, ss2, ss3}); else n_pass++;
`endif
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        // Start a jump, then pulse reset between edges while lat-3 is in WAIT.
        jump_start = 1'b1;
        @(negedge clock);
        jump_start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (st1 !== 2'b00) $display("FAIL async_reset_st1 got=%b want=00", st1); else n_pass++;
        n_total++; if (st3 !== 2'b00) $display("FAIL async_reset_st3 got=%b want=00", st3); else n_pass++;
        #1 reset_n = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if ({st1, st2, st3} !== 6'b0)
                $display("FAIL post_reset_idle cyc%0d got=%b/%b/%b want=00/00/00", k, st1, st2, st3);
            else n_pass++;
            @(negedge clock);
        end
    endtask

    task automatic test_jump();
        logic [1:0] e1 [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [1:0] e2 [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        logic [1:0] e3 [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        logic [1:0] x;
        logic       w;
        for (int k = 0; k < 6; k++) begin
            q1.push_back(e1[k]); q2.push_back(e2[k]); q3.push_back(e3[k]); qw.push_back(1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            jump_start = (k == 0);
            // A hazard while every instance is mid-jump must not raise want_stall.
            if (k == 1) set_hazard(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
            else        set_hazard(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            #1;
            x = q1.pop_front(); n_total++; if (st1 !== x) $display("FAIL jump_lat1 cyc%0d got=%b want=%b", k, st1, x); else n_pass++;
            x = q2.pop_front(); n_total++; if (st2 !== x) $display("FAIL jump_lat2 cyc%0d got=%b want=%b", k, st2, x); else n_pass++;
            x = q3.pop_front(); n_total++; if (st3 !== x) $display("FAIL jump_lat3 cyc%0d got=%b want=%b", k, st3, x); else n_pass++;
            w = qw.pop_front(); n_total++; if ({ws1, ws2, ws3} !== {3{w}}) $display("FAIL jump_stall cyc%0d got=%b want=%b", k, {ws1, ws2, ws3}, {3{w}}); else n_pass++;
            @(negedge clock);
        end
`ifdef BRANCH_HAZARD_STATS_EN
        ej1++; ej2++; ej3++;
        #1;
        n_total++; if ({sj1, sj2, sj3} !== {ej1, ej2, ej3}) $display("FAIL jump_stats got=%h want=%h", {sj1, sj2, sj3}, {ej1, ej2, ej3}); else n_pass++;
`endif
    endtask

    task automatic test_load_use();
        logic       ld [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0] rd [6] = '{5'd5, 5'd0, 5'd5, 5'd7, 5'd7, 5'd9};
        logic       u1 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0] r1 [6] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd9};
        logic       u2 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0] r2 [6] = '{5'd5, 5'd0, 5'd5, 5'd0, 5'd0, 5'd9};
        logic       ex [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       w;
        for (int k = 0; k < 6; k++) begin
            set_hazard(ld[k], rd[k], u1[k], r1[k], u2[k], r2[k]);
            qw.push_back(ex[k]);
`ifdef BRANCH_HAZARD_STATS_EN
            if (ex[k]) es++;
`endif
            #1;
            w = qw.pop_front();
            n_total++;
            if ({ws1, ws2, ws3} !== {3{w}})
                $display("FAIL load_use pat%0d got=%b want=%b", k, {ws1, ws2, ws3}, {3{w}});
            else n_pass++;
            @(negedge clock);
        end
        set_hazard(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
`ifdef BRANCH_HAZARD_STATS_EN
        #1;
        n_total++; if ({ss1, ss2, ss3} !== {3{es}}) $display("FAIL load_use_stats got=%h want=%h", {ss1, ss2, ss3}, {3{es}}); else n_pass++;
`endif
    endtask

    task automatic test_stall_beats_jump();
        logic [1:0] e1 [7] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [1:0] e2 [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        logic [1:0] e3 [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        logic [1:0] x;
        logic       w;
        for (int k = 0; k < 7; k++) begin
            q1.push_back(e1[k]); q2.push_back(e2[k]); q3.push_back(e3[k]); qw.push_back(k == 0);
        end
        for (int k = 0; k < 7; k++) begin
            jump_start = (k < 2);
            if (k == 0) set_hazard(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
            else        set_hazard(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            #1;
            x = q1.pop_front(); n_total++; if (st1 !== x) $display("FAIL stall_jump_lat1 cyc%0d got=%b want=%b", k, st1, x); else n_pass++;
            x = q2.pop_front(); n_total++; if (st2 !== x) $display("FAIL stall_jump_lat2 cyc%0d got=%b want=%b", k, st2, x); else n_pass++;
            x = q3.pop_front(); n_total++; if (st3 !== x) $display("FAIL stall_jump_lat3 cyc%0d got=%b want=%b", k, st3, x); else n_pass++;
            w = qw.pop_front(); n_total++; if ({ws1, ws2, ws3} !== {3{w}}) $display("FAIL stall_jump_stall cyc%0d got=%b want=%b", k, {ws1, ws2, ws3}, {3{w}}); else n_pass++;
            @(negedge clock);
        end
        jump_start = 1'b0;
`ifdef BRANCH_HAZARD_STATS_EN
        ej1++; ej2++; ej3++; es++;
        #1;
        n_total++; if ({sj1, sj2, sj3, ss1} !== {ej1, ej2, ej3, es}) $display("FAIL stall_jump_stats got=%h want=%h", {sj1, sj2, sj3, ss1}, {ej1, ej2, ej3, es}); else n_pass++;
`endif
    endtask

    task automatic test_flush();
        logic [1:0] e1 [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        logic [1:0] e2 [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        logic [1:0] e3 [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0] x;
        for (int k = 0; k < 5; k++) begin
            q1.push_back(e1[k]); q2.push_back(e2[k]); q3.push_back(e3[k]);
        end
        for (int k = 0; k < 5; k++) begin
            jump_start = (k == 0);
            flush      = (k == 2);
            #1;
            x = q1.pop_front(); n_total++; if (st1 !== x) $display("FAIL flush_lat1 cyc%0d got=%b want=%b", k, st1, x); else n_pass++;
            x = q2.pop_front(); n_total++; if (st2 !== x) $display("FAIL flush_lat2 cyc%0d got=%b want=%b", k, st2, x); else n_pass++;
            x = q3.pop_front(); n_total++; if (st3 !== x) $display("FAIL flush_lat3 cyc%0d got=%b want=%b", k, st3, x); else n_pass++;
            @(negedge clock);
        end
        flush = 1'b0;
        jump_start = 1'b0;
`ifdef BRANCH_HAZARD_STATS_EN
        #1;
        n_total++; if ({sj1, sj2, sj3} !== {ej1, ej2, ej3}) $display("FAIL flush_stats got=%h want=%h", {sj1, sj2, sj3}, {ej1, ej2, ej3}); else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [1:0] e1 [9] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [1:0] e2 [9] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        logic [1:0] e3 [9] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0] x;
        for (int k = 0; k < 9; k++) begin
            q1.push_back(e1[k]); q2.push_back(e2[k]); q3.push_back(e3[k]);
        end
        for (int k = 0; k < 9; k++) begin
            jump_start = (k < 5);
            #1;
            x = q1.pop_front(); n_total++; if (st1 !== x) $display("FAIL b2b_lat1 cyc%0d got=%b want=%b", k, st1, x); else n_pass++;
            x = q2.pop_front(); n_total++; if (st2 !== x) $display("FAIL b2b_lat2 cyc%0d got=%b want=%b", k, st2, x); else n_pass++;
            x = q3.pop_front(); n_total++; if (st3 !== x) $display("FAIL b2b_lat3 cyc%0d got=%b want=%b", k, st3, x); else n_pass++;
            @(negedge clock);
        end
        jump_start = 1'b0;
`ifdef BRANCH_HAZARD_STATS_EN
        ej1 += 4'd2; ej2 += 4'd2; ej3 += 4'd1;
        #1;
        n_total++; if ({sj1, sj2, sj3} !== {ej1, ej2, ej3}) $display("FAIL b2b_stats got=%h want=%h", {sj1, sj2, sj3}, {ej1, ej2, ej3}); else n_pass++;
`endif
    endtask

`ifdef BRANCH_HAZARD_STATS_EN
    task automatic test_stats_wrap();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        ej1 = '0; ej2 = '0; ej3 = '0; es = '0;
        set_hazard(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0);
        repeat (3) begin
            es++;
            @(negedge clock);
        end
        set_hazard(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        n_total++; if ({ss1, ss2, ss3} !== {3{es}}) $display("FAIL stats_stalls got=%h want=%h", {ss1, ss2, ss3}, {3{es}}); else n_pass++;
        for (int j = 0; j < 16; j++) begin
            jump_start = 1'b1;
            @(negedge clock);
            jump_start = 1'b0;
            repeat (5) @(negedge clock);
            ej1++; ej2++; ej3++;
            if (j == 7) begin
                #1;
                n_total++; if (sj2 !== ej2) $display("FAIL stats_jumps_mid got=%0d want=%0d", sj2, ej2); else n_pass++;
            end
        end
        #1;
        n_total++; if ({sj1, sj2, sj3} !== {ej1, ej2, ej3}) $display("FAIL stats_wrap got=%h want=%h", {sj1, sj2, sj3}, {ej1, ej2, ej3}); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_jump();
        test_load_use();
        test_stall_beats_jump();
        test_flush();
        test_back_to_back();
`ifdef BRANCH_HAZARD_STATS_EN
        test_stats_wrap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
